// File: rtl/morse_encoder_tx.sv
// Morse transmit encoder: takes one character code per handshake and keys tx_out
// with unit timing paced by the external tick enable.
module morse_encoder_tx #(
  parameter int DOT_UNITS        = 1,
  parameter int DASH_UNITS       = 3,
  parameter int SYM_GAP_UNITS    = 1,
  parameter int LETTER_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS   = 7,
  parameter int CNT_W            = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       tick,
  input  logic       char_valid,
  input  logic [4:0] char_code,
  output logic       char_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       sym_dash,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, ALIGN, MARK, SGAP, LGAP, WGAP} state_t;

  localparam logic [CNT_W-1:0] DOT_LAST  = CNT_W'(DOT_UNITS - 1);
  localparam logic [CNT_W-1:0] DASH_LAST = CNT_W'(DASH_UNITS - 1);
  localparam logic [CNT_W-1:0] SGAP_LAST = CNT_W'(SYM_GAP_UNITS - 1);
  localparam logic [CNT_W-1:0] LGAP_LAST = CNT_W'(LETTER_GAP_UNITS - 1);
  localparam logic [CNT_W-1:0] WGAP_LAST = CNT_W'(WORD_GAP_UNITS - 1);

  // {length, pattern}; pattern is left-aligned, bit 3 is the first symbol, 1 = dash
  function automatic logic [6:0] rom_lookup(input logic [4:0] code);
    case (code)
      5'd0:    return {3'd2, 4'b0100}; // A .-
      5'd1:    return {3'd4, 4'b1000}; // B -...
      5'd2:    return {3'd4, 4'b1010}; // C -.-.
      5'd3:    return {3'd3, 4'b1000}; // D -..
      5'd4:    return {3'd1, 4'b0000}; // E .
      5'd5:    return {3'd4, 4'b0010}; // F ..-.
      5'd6:    return {3'd3, 4'b1100}; // G --.
      5'd7:    return {3'd4, 4'b0000}; // H ....
      5'd8:    return {3'd2, 4'b0000}; // I ..
      5'd9:    return {3'd4, 4'b0111}; // J .---
      5'd10:   return {3'd3, 4'b1010}; // K -.-
      5'd11:   return {3'd4, 4'b0100}; // L .-..
      5'd12:   return {3'd2, 4'b1100}; // M --
      5'd13:   return {3'd2, 4'b1000}; // N -.
      5'd14:   return {3'd3, 4'b1110}; // O ---
      5'd15:   return {3'd4, 4'b0110}; // P .--.
      5'd16:   return {3'd4, 4'b1101}; // Q --.-
      5'd17:   return {3'd3, 4'b0100}; // R .-.
      5'd18:   return {3'd3, 4'b0000}; // S ...
      5'd19:   return {3'd1, 4'b1000}; // T -
      5'd20:   return {3'd3, 4'b0010}; // U ..-
      5'd21:   return {3'd4, 4'b0001}; // V ...-
      5'd22:   return {3'd3, 4'b0110}; // W .--
      5'd23:   return {3'd4, 4'b1001}; // X -..-
      5'd24:   return {3'd4, 4'b1011}; // Y -.--
      5'd25:   return {3'd4, 4'b1100}; // Z --..
      default: return 7'd0;
    endcase
  endfunction

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       pat_reg, pat_next;
  logic [2:0]       len_reg, len_next;
  logic [1:0]       idx_reg, idx_next;
  logic             space_reg, space_next;
  logic             tx_reg, tx_next;
  logic             dash_reg, dash_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  logic [6:0]       rom_word;
  logic             cur_dash;
  logic             last_sym;
  logic [CNT_W-1:0] mark_last;

  assign rom_word  = rom_lookup(char_code);
  assign cur_dash  = pat_reg[2'd3 - idx_reg];
  assign last_sym  = ({1'b0, idx_reg} == (len_reg - 3'd1));
  assign mark_last = cur_dash ? DASH_LAST : DOT_LAST;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pat_next   = pat_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    space_next = space_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        // A tick on the accept edge is deliberately ignored; ALIGN waits for the next one
        if (char_valid) begin
          cnt_next = '0;
          idx_next = 2'd0;
          if (char_code < 5'd26) begin
            pat_next   = rom_word[3:0];
            len_next   = rom_word[6:4];
            space_next = 1'b0;
            state_next = ALIGN;
          end else if (char_code == 5'd26) begin
            space_next = 1'b1;
            state_next = ALIGN;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ALIGN: begin
        if (tick) begin
          cnt_next   = '0;
          state_next = space_reg ? WGAP : MARK;
        end
      end
      MARK: begin
        if (tick) begin
          if (cnt_reg == mark_last) begin
            cnt_next   = '0;
            state_next = last_sym ? LGAP : SGAP;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      SGAP: begin
        if (tick) begin
          if (cnt_reg == SGAP_LAST) begin
            cnt_next   = '0;
            idx_next   = idx_reg + 2'd1;
            state_next = MARK;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      LGAP: begin
        if (tick) begin
          if (cnt_reg == LGAP_LAST) begin
            cnt_next   = '0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      WGAP: begin
        if (tick) begin
          if (cnt_reg == WGAP_LAST) begin
            cnt_next   = '0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Keying outputs are registered from the next state so edges line up with state changes
    tx_next   = (state_next == MARK);
    dash_next = (state_next == MARK) && pat_next[2'd3 - idx_next];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      pat_reg   <= '0;
      len_reg   <= '0;
      idx_reg   <= '0;
      space_reg <= 1'b0;
      tx_reg    <= 1'b0;
      dash_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pat_reg   <= pat_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      space_reg <= space_next;
      tx_reg    <= tx_next;
      dash_reg  <= dash_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign char_ready = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign tx_out     = tx_reg;
  assign sym_dash   = dash_reg;
  assign done       = done_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_morse_encoder_tx.sv
// Directed bench for morse_encoder_tx: expected keying events are queued at send
// time and compared as the monitor observes marks, gaps, done and err.
module tb_morse_encoder_tx;

  localparam int TPU = 4; // clock cycles per tick

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       tick = 1'b0;
  logic       char_valid = 1'b0;
  logic [4:0] char_code = 5'd0;
  logic       char_ready, tx_out, busy, sym_dash, done, err;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int done_cnt = 0;
  int mon_marks = 0;
  string morse [26];

  morse_encoder_tx dut (
    .CLK(CLK), .RST_N(RST_N), .tick(tick), .char_valid(char_valid),
    .char_code(char_code), .char_ready(char_ready), .tx_out(tx_out),
    .busy(busy), .sym_dash(sym_dash), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  initial begin
    int tph;
    tph = 0;
    forever begin
      @(negedge CLK);
      tick = (tph == TPU - 1);
      tph = (tph + 1) % TPU;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic ev(input string tag, input int obs);
    int e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    check(tag, obs, e);
  endtask

  // Event encoding: 1xxxx mark (len*2+dash), 2xxxx gap, 3xxxx done (final gap), 40000 err
  task automatic push_char(input int code);
    string s;
    int    d;
    if (code < 26) begin
      s = morse[code];
      for (int i = 0; i < s.len(); i++) begin
        d = (s[i] == "-") ? 1 : 0;
        exp_q.push_back(10000 + (d ? 3 : 1) * TPU * 2 + d);
        if (i < s.len() - 1) exp_q.push_back(20000 + TPU);
      end
      exp_q.push_back(30000 + 3 * TPU);
    end else if (code == 26) begin
      exp_q.push_back(30000 + 7 * TPU);
    end else begin
      exp_q.push_back(40000);
    end
  endtask

  // Monitor samples just after each rising edge
  initial begin
    int cyc, seg_start;
    logic prev_tx, prev_busy, prev_dash, aligned;
    cyc = 0; seg_start = 0;
    prev_tx = 0; prev_busy = 0; prev_dash = 0; aligned = 0;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (!RST_N) begin
        prev_tx = 0; prev_busy = 0; prev_dash = 0; aligned = 0; mon_marks = 0;
      end else begin
        if (busy && !prev_busy) begin
          aligned = 0;
          mon_marks = 0;
        end
        if (busy && prev_busy && !aligned && tick) begin
          aligned = 1;
          seg_start = cyc;
        end
        if (tx_out !== prev_tx) begin
          if (prev_tx) begin
            ev("MARK", 10000 + (cyc - seg_start) * 2 + int'(prev_dash));
            mon_marks++;
          end else if (mon_marks > 0) begin
            ev("GAP", 20000 + (cyc - seg_start));
          end else begin
            check("MARK_AT_ALIGN", aligned ? (cyc - seg_start) : -1, 0);
          end
          seg_start = cyc;
        end
        if (done) begin
          done_cnt++;
          ev("DONE", 30000 + (cyc - seg_start));
          check("READY_AT_DONE", char_ready, 1'b1);
        end
        if (err) begin
          ev("ERR", 40000);
          check("ERR_NOT_BUSY", busy, 1'b0);
          check("ERR_TX_LOW", tx_out, 1'b0);
        end
        prev_tx = tx_out;
        prev_busy = busy;
        prev_dash = sym_dash;
      end
    end
  end

  task automatic send(input logic [4:0] code);
    int i;
    @(negedge CLK);
    char_code = code;
    char_valid = 1'b1;
    for (i = 0; i < 200 && !char_ready; i++) @(negedge CLK);
    check("ACCEPT_READY", char_ready, 1'b1);
    @(posedge CLK);
    #2;
    char_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK);
      #2;
      if (exp_q.size() == 0 && !busy) break;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL WATCHDOG observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    morse = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
              "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
              "..-", "...-", ".--", "-..-", "-.--", "--.."};

    // Reset state
    repeat (3) @(posedge CLK);
    #2;
    check("RST_READY", char_ready, 1'b1);
    check("RST_TX", tx_out, 1'b0);
    check("RST_BUSY", busy, 1'b0);
    check("RST_DASH", sym_dash, 1'b0);
    check("RST_DONE", done, 1'b0);
    check("RST_ERR", err, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;

    // E then A
    push_char(4);  send(5'd4);  wait_quiet("QUIET_E", 300);
    push_char(0);  send(5'd0);  wait_quiet("QUIET_A", 300);
    check("IDLE_READY", char_ready, 1'b1);

    // T then S with char_valid held across the done cycle
    push_char(19); push_char(18);
    d0 = done_cnt;
    @(negedge CLK);
    char_code = 5'd19;
    char_valid = 1'b1;
    @(posedge CLK);
    #2;
    char_code = 5'd18;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge CLK);
      #2;
    end
    check("T_DONE_SEEN", done, 1'b1);
    @(posedge CLK);
    #2;
    check("S_BACK_TO_BACK", busy, 1'b1);
    char_valid = 1'b0;
    wait_quiet("QUIET_TS", 300);
    check("TS_DONE_COUNT", done_cnt - d0, 2);

    // Word space
    push_char(26); send(5'd26); wait_quiet("QUIET_SPACE", 300);

    // Invalid code
    d0 = done_cnt;
    push_char(29); send(5'd29);
    repeat (10) @(posedge CLK);
    #2;
    check("INV_QUEUE", exp_q.size(), 0);
    check("INV_BUSY", busy, 1'b0);
    check("INV_NO_DONE", done_cnt - d0, 0);

    // O aborted by reset during its second dash
    push_char(14); send(5'd14);
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK);
      #2;
      if (mon_marks == 1 && tx_out) break;
    end
    check("O_SECOND_DASH", tx_out, 1'b1);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    check("ASYNC_TX", tx_out, 1'b0);
    check("ASYNC_READY", char_ready, 1'b1);
    exp_q.delete();
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #2;
    check("POST_RST_READY", char_ready, 1'b1);
    check("POST_RST_BUSY", busy, 1'b0);

    push_char(4); send(5'd4); wait_quiet("QUIET_E2", 300);

    // A couple of longer letters for extra pattern coverage
    push_char(16); send(5'd16); wait_quiet("QUIET_Q", 300);
    push_char(14); send(5'd14); wait_quiet("QUIET_O", 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
